pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 53 +++++
 rtl/pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
// master: datapath side (drives ID/EX hazard info, receives stall/flush/halt).
// slave : hazard controller (reads hazard info, drives pipeline control).
interface pipeline_hazard_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  // ID-stage instruction info
  logic [REG_W-1:0] ID_src1_reg;
  logic [REG_W-1:0] ID_src2_reg;
  logic             ID_use_src1;
  logic             ID_use_src2;
  logic             ID_sprite_re;
  logic             ID_sprite_we;
  logic             ID_hlt;

  // EX-stage writeback / branch info
  logic [REG_W-1:0] EX_dst_reg;
  logic             EX_use_dst_reg;
  logic             EX_mem_re;
  logic             EX_use_sprite_mem;
  logic             EX_branch_taken;

  logic             sprite_busy;

  // Pipeline control
  logic             pc_hold;
  logic             IF_ID_stall;
  logic             IF_ID_flush;
  logic             ID_EX_stall;
  logic             ID_EX_flush;
  logic             hlt;
  logic             sprite_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output ID_src1_reg, ID_src2_reg, ID_use_src1, ID_use_src2,
           ID_sprite_re, ID_sprite_we, ID_hlt,
           EX_dst_reg, EX_use_dst_reg, EX_mem_re, EX_use_sprite_mem,
           EX_branch_taken, sprite_busy,
    input  pc_hold, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           hlt, sprite_timeout, stall_cycles
  );

  modport slave (
    input  ID_src1_reg, ID_src2_reg, ID_use_src1, ID_use_src2,
           ID_sprite_re, ID_sprite_we, ID_hlt,
           EX_dst_reg, EX_use_dst_reg, EX_mem_re, EX_use_sprite_mem,
           EX_branch_taken, sprite_busy,
    output pc_hold, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           hlt, sprite_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use and sprite-busy stalls, branch flush,
// halt, plus a sticky sprite-wait timeout flag and a saturating stall counter.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   hz    - pipeline_hazard_ctrl_if.slave: ID/EX hazard info in; pc_hold,
//           IF_ID_stall/flush, ID_EX_stall/flush, hlt (combinational from
//           state + inputs), sprite_timeout and stall_cycles (registered) out.
module pipeline_hazard_ctrl (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_WAIT   = 2'd1,
    SPRITE_WAIT = 2'd2,
    HALT        = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_cnt_nxt;
  logic                sprite_timeout_q;
  logic [CNT_W-1:0]    stall_cnt;

  logic                load_hazard_c;
  logic                sprite_hazard_c;
  logic                timeout_set_c;
  logic                pc_hold_c;
  logic                if_id_stall_c;
  logic                if_id_flush_c;
  logic                id_ex_stall_c;
  logic                id_ex_flush_c;
  logic                hlt_c;

  // Hazard detection; register 0 is never a real dependency
  always_comb begin
    load_hazard_c = hz.EX_mem_re & hz.EX_use_dst_reg & (hz.EX_dst_reg != '0) &
                    ((hz.ID_use_src1 & (hz.ID_src1_reg == hz.EX_dst_reg)) |
                     (hz.ID_use_src2 & (hz.ID_src2_reg == hz.EX_dst_reg)));
    sprite_hazard_c = (hz.ID_sprite_re | hz.ID_sprite_we) & hz.sprite_busy;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    timeout_set_c = 1'b0;
    pc_hold_c     = 1'b0;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_stall_c = 1'b0;
    id_ex_flush_c = 1'b0;
    hlt_c         = 1'b0;

    case (state)
      RUN: begin
        if (hz.EX_branch_taken) begin
          // Wrong-path instruction in ID is squashed; its hazards don't matter
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (load_hazard_c) begin
          pc_hold_c     = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
          // Sprite-memory loads return a cycle later: second bubble
          if (hz.EX_use_sprite_mem) begin
            state_nxt = LOAD_WAIT;
          end
        end else if (sprite_hazard_c) begin
          pc_hold_c     = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
          wait_cnt_nxt  = '0;
          state_nxt     = SPRITE_WAIT;
        end else if (hz.ID_hlt) begin
          // Keep the halt itself out of EX
          id_ex_flush_c = 1'b1;
          state_nxt     = HALT;
        end
      end

      LOAD_WAIT: begin
        // EX holds a bubble, so a branch indication here is meaningless
        pc_hold_c     = 1'b1;
        if_id_stall_c = 1'b1;
        id_ex_flush_c = 1'b1;
        state_nxt     = RUN;
      end

      SPRITE_WAIT: begin
        if (!hz.sprite_busy) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_MAX) begin
          // Give up waiting: flag it and let the request through
          timeout_set_c = 1'b1;
          state_nxt     = RUN;
        end else begin
          pc_hold_c     = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
          wait_cnt_nxt  = wait_cnt + WAIT_W'(1);
        end
      end

      HALT: begin
        hlt_c         = 1'b1;
        pc_hold_c     = 1'b1;
        if_id_stall_c = 1'b1;
        id_ex_stall_c = 1'b1;
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Sprite wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt         <= '0;
      sprite_timeout_q <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if (timeout_set_c) begin
        sprite_timeout_q <= 1'b1;
      end
    end
  end

  // Saturating count of IF/ID stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (if_id_stall_c && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign hz.pc_hold        = pc_hold_c;
  assign hz.IF_ID_stall    = if_id_stall_c;
  assign hz.IF_ID_flush    = if_id_flush_c;
  assign hz.ID_EX_stall    = id_ex_stall_c;
  assign hz.ID_EX_flush    = id_ex_flush_c;
  assign hz.hlt            = hlt_c;
  assign hz.sprite_timeout = sprite_timeout_q;
  assign hz.stall_cycles   = stall_cnt;

endmodule
